// File: rtl/axi_master_wr.sv
// AXI4 write master: takes a burst request, drives AW/W/B toward the slave and
// pulls write data from a first-word-fall-through FIFO.
module axi_master_wr #(
    parameter int unsigned AXI_ID_WIDTH = 4,
    parameter int unsigned AXI_ID       = 0,
    parameter int unsigned ADDR_WIDTH   = 30,
    parameter int unsigned DATA_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_start,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [7:0]              wr_len,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    wr_ready,
    output logic                    wr_writing,
    output logic                    wr_done,
    output logic                    wr_err,
    output logic [AXI_ID_WIDTH-1:0] m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [AXI_ID_WIDTH-1:0] m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]  AW_SIZE    = 3'($clog2(STRB_WIDTH));

    typedef enum logic [1:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  wlast_q, wlast_d;
    logic                  bready_q, bready_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  w_hs;
    logic                  unused_bid;

    assign w_hs       = wvalid_q & m_axi_wready;
    assign unused_bid = ^m_axi_bid;

    // Next-state and registered-output computation
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        wlast_d    = wlast_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (wr_start) begin
                    addr_d     = wr_addr;
                    len_d      = wr_len;
                    beat_cnt_d = 8'd0;
                    state_d    = S_AW;
                end
            end
            S_AW: begin
                if (awvalid_q && m_axi_awready) begin
                    wlast_d = (len_q == 8'd0);
                    state_d = S_W;
                end
            end
            S_W: begin
                if (w_hs) begin
                    beat_cnt_d = 8'(beat_cnt_q + 8'd1);
                    if (wlast_q) begin
                        wlast_d = 1'b0;
                        state_d = S_B;
                    end else begin
                        wlast_d = (8'(beat_cnt_q + 8'd1) == len_q);
                    end
                end
            end
            S_B: begin
                if (bready_q && m_axi_bvalid) begin
                    done_d  = 1'b1;
                    err_d   = (m_axi_bresp != 2'b00);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ready_d = (state_d == S_IDLE);
        awvalid_d  = (state_d == S_AW);
        wvalid_d   = (state_d == S_W);
        bready_d   = (state_d == S_B);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            len_q      <= 8'd0;
            beat_cnt_q <= 8'd0;
            wr_ready_q <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
            bready_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            wr_ready_q <= wr_ready_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            wlast_q    <= wlast_d;
            bready_q   <= bready_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign wr_ready      = wr_ready_q;
    assign wr_writing    = w_hs;
    assign wr_done       = done_q;
    assign wr_err        = err_q;
    assign m_axi_awid    = AXI_ID_WIDTH'(AXI_ID);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = AW_SIZE;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wr_data;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = wlast_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;

endmodule

// File: tb/tb_axi_master_wr.sv
// Randomized scoreboard bench for axi_master_wr with an AXI slave and FWFT FIFO model.
module tb_axi_master_wr;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_start;
    logic [29:0] wr_addr;
    logic [7:0]  wr_len;
    logic [63:0] wr_data;
    logic        wr_ready, wr_writing, wr_done, wr_err;
    logic [3:0]  awid;
    logic [29:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    always #5 clk = ~clk;

    axi_master_wr dut (
        .clk(clk), .rst(rst), .wr_start(wr_start), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_data(wr_data), .wr_ready(wr_ready), .wr_writing(wr_writing), .wr_done(wr_done),
        .wr_err(wr_err), .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
        .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready)
    );

    typedef struct { logic [29:0] a; logic [7:0] l; } aw_t;
    typedef struct { logic [63:0] d; logic last; } beat_t;

    aw_t         aw_exp[$];
    beat_t       w_exp[$];
    logic        b_exp[$];
    logic [1:0]  resp_q[$];
    logic [63:0] fifo[$];

    int total = 0;
    int bad   = 0;
    int beats_seen = 0;
    int aw_stall = 0;
    int aw_cnt   = 0;
    int w_mode   = 0;
    logic done_next = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Slave model: AW stall counter, W ready pattern, delayed B response, FIFO pop
    initial begin : slave
        logic pop, last_hs, b_hs, b_pending;
        int   b_wait;
        b_pending = 1'b0;
        b_wait    = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = 4'd0;
        wr_data = 64'd0;
        forever begin
            @(negedge clk);
            pop = 1'b0; last_hs = 1'b0; b_hs = 1'b0;
            if (rst) begin
                b_pending = 1'b0;
                bvalid    = 1'b0;
                aw_cnt    = aw_stall;
            end else begin
                if (awvalid && awready)       aw_cnt = aw_stall;
                else if (awvalid && aw_cnt > 0) aw_cnt--;
                if (wvalid && wready) begin
                    pop = 1'b1;
                    last_hs = wlast;
                end
                b_hs = bvalid && bready;
            end
            @(posedge clk);
            #1;
            if (pop && fifo.size() > 0) void'(fifo.pop_front());
            wr_data = (fifo.size() > 0) ? fifo[0] : 64'd0;
            if (b_hs) bvalid = 1'b0;
            if (last_hs) begin
                b_pending = 1'b1;
                b_wait    = $urandom_range(0, 3);
            end
            if (b_pending && !bvalid) begin
                if (b_wait == 0) begin
                    bvalid    = 1'b1;
                    bresp     = (resp_q.size() > 0) ? resp_q.pop_front() : 2'b00;
                    b_pending = 1'b0;
                end else begin
                    b_wait--;
                end
            end
            awready = (aw_cnt == 0);
            case (w_mode)
                0:       wready = 1'b1;
                1:       wready = ~wready;
                default: wready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compare every DUT handshake against the expectation queues
    initial begin : monitor
        logic        aw_ok, w_stall, a_stall, sl;
        logic [63:0] sd;
        logic [29:0] sa;
        aw_t         ea;
        beat_t       eb;
        aw_ok = 1'b0; w_stall = 1'b0; a_stall = 1'b0; sl = 1'b0; sd = '0; sa = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_ok = 1'b0; w_stall = 1'b0; a_stall = 1'b0; done_next = 1'b0;
            end else begin
                if (done_next) begin
                    chk("done_after_b", wr_done, 1'b1);
                    chk("ready_at_done", wr_ready, 1'b1);
                    if (b_exp.size() > 0) chk("err_flag", wr_err, b_exp.pop_front());
                    else chk("done_unexpected", 1'b1, 1'b0);
                end else if (wr_done) begin
                    chk("spurious_done", wr_done, 1'b0);
                end
                if (wr_err && !wr_done) chk("err_without_done", wr_err, 1'b0);
                done_next = bvalid && bready;

                if (wr_ready && (awvalid || wvalid || bready))
                    chk("ready_while_busy", wr_ready, 1'b0);
                if (awvalid) begin
                    chk("no_w_during_aw", wvalid, 1'b0);
                    if (a_stall) chk("awaddr_stable", awaddr, sa);
                end
                if (awvalid && awready) begin
                    if (aw_exp.size() > 0) begin
                        ea = aw_exp.pop_front();
                        chk("awaddr", awaddr, ea.a);
                        chk("awlen", awlen, ea.l);
                        chk("aw_consts", {awid, awsize, awburst}, {4'd0, 3'd3, 2'b01});
                    end else chk("aw_unexpected", 1'b1, 1'b0);
                    aw_ok = 1'b1;
                end
                a_stall = awvalid && !awready;
                sa      = awaddr;

                if (wvalid) chk("w_after_aw", aw_ok, 1'b1);
                if (wvalid || wr_writing) chk("wr_writing", wr_writing, wvalid && wready);
                if (w_stall) begin
                    chk("wdata_stable", wdata, sd);
                    chk("wlast_stable", wlast, sl);
                end
                if (wvalid && wready) begin
                    if (w_exp.size() > 0) begin
                        eb = w_exp.pop_front();
                        chk("wdata", wdata, eb.d);
                        chk("wlast", wlast, eb.last);
                        chk("wstrb", wstrb, 8'hff);
                    end else chk("w_unexpected", 1'b1, 1'b0);
                    beats_seen++;
                    if (wlast) aw_ok = 1'b0;
                end
                w_stall = wvalid && !wready;
                sd      = wdata;
                sl      = wlast;
            end
        end
    end

    task automatic issue(input logic [29:0] a, input logic [7:0] l, input logic [1:0] resp);
        bit   seen;
        aw_t  e;
        beat_t b;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("issue_timeout", 1'b0, 1'b1);
            return;
        end
        e.a = a; e.l = l;
        aw_exp.push_back(e);
        for (int i = 0; i <= int'(l); i++) begin
            b.d = {$urandom, $urandom};
            b.last = (i == int'(l));
            w_exp.push_back(b);
            fifo.push_back(b.d);
        end
        b_exp.push_back(resp != 2'b00);
        resp_q.push_back(resp);
        wr_start = 1'b1; wr_addr = a; wr_len = l;
        @(posedge clk);
        #1 wr_start = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (aw_exp.size() == 0 && w_exp.size() == 0 && b_exp.size() == 0 && !done_next) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("drain_timeout", 1'b0, 1'b1);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int base;
        rst = 1'b1; wr_start = 1'b0; wr_addr = '0; wr_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {wr_ready, awvalid, wvalid, bready, wr_done, wr_err}, 6'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_outputs_hold", {awvalid, wvalid, bready, wr_done, wr_err}, 5'b0);
        @(negedge clk);
        chk("ready_after_reset", wr_ready, 1'b1);

        // basic, single beat, stalled W, stalled AW, error response
        issue(30'h100, 8'd7, 2'b00);  drain();
        issue(30'h140, 8'd0, 2'b00);  drain();
        w_mode = 1;
        issue(30'h180, 8'd15, 2'b00); drain();
        w_mode = 0; aw_stall = 5; aw_cnt = 5;
        issue(30'h200, 8'd3, 2'b00);  drain();
        aw_stall = 0; aw_cnt = 0;
        issue(30'h240, 8'd2, 2'b10);
        issue(30'h280, 8'd1, 2'b00);  drain();

        // reset in the middle of a burst
        base = beats_seen;
        issue(30'h300, 8'd7, 2'b00);
        for (int i = 0; i < 200 && beats_seen < base + 3; i++) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        aw_exp.delete(); w_exp.delete(); b_exp.delete(); resp_q.delete(); fifo.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {awvalid, wvalid, bready, wr_done, wr_err}, 5'b0);
        repeat (8) @(negedge clk);
        issue(30'h340, 8'd3, 2'b00);  drain();

        // randomized back-to-back bursts
        for (int n = 0; n < 30; n++) begin
            w_mode   = $urandom_range(0, 2);
            aw_stall = $urandom_range(0, 3);
            issue(30'($urandom_range(0, 4095)) << 6,
                  ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 63)) : 8'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
        end
        drain();
        aw_stall = 0;
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
